// File: rtl/if_fetch.sv
// Instruction-fetch front end feeding the IF/ID pipeline register.
//
// Each 32-bit instruction is read as four little-endian bytes over a byte-wide
// memory port with one cycle of read latency. A completed instruction is shown
// on if_pc/if_inst with if_valid. It stays there while stall_in is high.
// A redirect (jump_en) aborts any fetch in progress and restarts at jump_target.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   stall_in     downstream not accepting; hold the presented instruction
//   jump_en      redirect request (single-cycle pulse)
//   jump_target  redirect PC; bits [1:0] are ignored
//   mem_din      read byte for the address issued in the previous cycle
//   mem_a        byte address to memory
//   mem_rd       read strobe
//   if_pc        PC of the presented instruction (registered)
//   if_inst      presented instruction (registered)
//   if_valid     if_pc/if_inst valid this cycle
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_rd,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [2:0] {
    StI0,
    StI1,
    StI2,
    StI3,
    StC3,
    StOut
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [7:0]  b2_q, b2_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  // Ungated decode of the memory strobe, address and valid flag.
  logic        rd_raw;
  logic [31:0] a_raw;
  logic        valid_raw;

  // The low target bits are dropped on purpose; redirects are word aligned.
  logic unused_tgt;
  assign unused_tgt = ^jump_target[1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    rd_raw    = 1'b0;
    a_raw     = pc_q;
    valid_raw = 1'b0;

    unique case (state_q)
      StI0: begin
        rd_raw  = 1'b1;
        a_raw   = pc_q;
        state_d = StI1;
      end
      StI1: begin
        rd_raw  = 1'b1;
        a_raw   = pc_q + 32'd1;
        b0_d    = mem_din;
        state_d = StI2;
      end
      StI2: begin
        rd_raw  = 1'b1;
        a_raw   = pc_q + 32'd2;
        b1_d    = mem_din;
        state_d = StI3;
      end
      StI3: begin
        rd_raw  = 1'b1;
        a_raw   = pc_q + 32'd3;
        b2_d    = mem_din;
        state_d = StC3;
      end
      StC3: begin
        // The last byte arrives this cycle, straight from mem_din.
        if_inst_d = {mem_din, b2_q, b1_q, b0_q};
        if_pc_d   = pc_q;
        state_d   = StOut;
      end
      StOut: begin
        valid_raw = 1'b1;
        if (!stall_in) begin
          pc_d    = pc_q + 32'd4;
          state_d = StI0;
        end
      end
      default: state_d = StI0;
    endcase

    // A redirect beats stall and the C3 capture. A read already issued this
    // cycle still goes out, and its data is ignored.
    if (jump_en) begin
      pc_d      = {jump_target[31:2], 2'b00};
      state_d   = StI0;
      if_pc_d   = if_pc_q;
      if_inst_d = if_inst_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StI0;
      pc_q      <= RESET_PC;
      b0_q      <= 8'h00;
      b1_q      <= 8'h00;
      b2_q      <= 8'h00;
      if_pc_q   <= 32'h0;
      if_inst_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
    end
  end

  // The memory-facing outputs and if_valid are forced quiet while reset is held.
  assign mem_rd   = rst & rd_raw;
  assign mem_a    = rst ? a_raw : 32'h0;
  assign if_valid = rst & valid_raw;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch with a small byte-wide memory model that has
// one cycle of read latency. Inputs change 1 ns after a rising edge.
// Outputs are sampled 1 ns later, so every check sees a settled cycle.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_rd;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] W0 = 32'h0050_0013;
  localparam logic [31:0] W1 = 32'h0010_0093;
  localparam logic [31:0] W2 = 32'h0020_8113;
  localparam logic [31:0] WJ = 32'hDEAD_BEEF;
  localparam logic [31:0] WT = 32'h1234_5678;

  if_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_in   (stall_in),
    .jump_en    (jump_en),
    .jump_target(jump_target),
    .mem_din    (mem_din),
    .mem_a      (mem_a),
    .mem_rd     (mem_rd),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_valid   (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian memory image; unlisted addresses read as zero.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_byte = 8'h13;
      32'h0000_0001: mem_byte = 8'h00;
      32'h0000_0002: mem_byte = 8'h50;
      32'h0000_0003: mem_byte = 8'h00;
      32'h0000_0004: mem_byte = 8'h93;
      32'h0000_0005: mem_byte = 8'h00;
      32'h0000_0006: mem_byte = 8'h10;
      32'h0000_0007: mem_byte = 8'h00;
      32'h0000_0008: mem_byte = 8'h13;
      32'h0000_0009: mem_byte = 8'h81;
      32'h0000_000A: mem_byte = 8'h20;
      32'h0000_000B: mem_byte = 8'h00;
      32'h0000_0010: mem_byte = 8'hAA;
      32'h0000_1004: mem_byte = 8'hEF;
      32'h0000_1005: mem_byte = 8'hBE;
      32'h0000_1006: mem_byte = 8'hAD;
      32'h0000_1007: mem_byte = 8'hDE;
      32'hFFFF_FFFC: mem_byte = 8'h78;
      32'hFFFF_FFFD: mem_byte = 8'h56;
      32'hFFFF_FFFE: mem_byte = 8'h34;
      32'hFFFF_FFFF: mem_byte = 8'h12;
      default:       mem_byte = 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_din <= mem_byte(mem_a);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an I0 cycle, already sampled. Walks the I0..C3 cycles and
  // ends sampled in the OUT cycle, checking the presented instruction there.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] inst);
    for (int k = 0; k < 4; k++) begin
      check_eq("fetch_rd", {31'b0, mem_rd}, 32'd1);
      check_eq("fetch_a", mem_a, pc + k);
      check_eq("fetch_nvalid", {31'b0, if_valid}, 32'd0);
      tick();
      #1;
    end
    check_eq("c3_rd", {31'b0, mem_rd}, 32'd0);
    check_eq("c3_nvalid", {31'b0, if_valid}, 32'd0);
    tick();
    #1;
    check_eq("out_valid", {31'b0, if_valid}, 32'd1);
    check_eq("out_rd", {31'b0, mem_rd}, 32'd0);
    check_eq("out_pc", if_pc, pc);
    check_eq("out_inst", if_inst, inst);
  endtask

  initial begin
    rst         = 1'b0;
    stall_in    = 1'b0;
    jump_en     = 1'b0;
    jump_target = 32'h0;

    // Reset state.
    repeat (3) tick();
    #1;
    check_eq("rst_rd", {31'b0, mem_rd}, 32'd0);
    check_eq("rst_a", mem_a, 32'h0);
    check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_inst", if_inst, 32'h0);

    // Release: cycle 1 is I0 at RESET_PC and cycle 6 is OUT.
    tick();
    rst = 1'b1;
    #1;
    run_fetch(32'h0, W0);

    // Back-to-back sequential fetches.
    tick();
    #1;
    run_fetch(32'h4, W1);
    tick();
    #1;
    run_fetch(32'h8, W2);

    // Stall in OUT for three edges: the output holds and no read is issued.
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) stall_in = 1'b0;
      #1;
      check_eq("stall_valid", {31'b0, if_valid}, 32'd1);
      check_eq("stall_rd", {31'b0, mem_rd}, 32'd0);
      check_eq("stall_pc", if_pc, 32'h8);
      check_eq("stall_inst", if_inst, W2);
    end
    tick();
    #1;
    check_eq("post_stall_a", mem_a, 32'hC);
    check_eq("post_stall_rd", {31'b0, mem_rd}, 32'd1);

    // Redirect while in I2 of the fetch at 0xC.
    tick();
    tick();
    jump_en     = 1'b1;
    jump_target = 32'h0000_1007;
    #1;
    check_eq("jump_cycle_a", mem_a, 32'hE);
    tick();
    jump_en = 1'b0;
    #1;
    check_eq("jump_held_inst", if_inst, W2);
    run_fetch(32'h0000_1004, WJ);

    // Redirect while stalled in OUT, to the top of the address space.
    stall_in    = 1'b1;
    jump_en     = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    tick();
    stall_in = 1'b0;
    jump_en  = 1'b0;
    #1;
    check_eq("jstall_nvalid", {31'b0, if_valid}, 32'd0);
    run_fetch(32'hFFFF_FFFC, WT);
    tick();
    #1;
    check_eq("wrap_a", mem_a, 32'h0);
    check_eq("wrap_rd", {31'b0, mem_rd}, 32'd1);

    // Reset during I3.
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_rd", {31'b0, mem_rd}, 32'd0);
    check_eq("midrst_valid", {31'b0, if_valid}, 32'd0);
    check_eq("midrst_a", mem_a, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_pc", if_pc, 32'h0);
    check_eq("midrst_inst", if_inst, 32'h0);
    run_fetch(32'h0, W0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
